argmax_sequencer: RTL
=====================

// Module: argmax_sequencer
// PURPOSE
//   Sequential classifier back-end for the output layer. Accepts N_CLASSES neuron
//   scores serially over a valid/ready stream and tracks a running maximum and its
//   index. It then presents the winning class index with a valid/ready result
//   handshake. It sits between the output-layer neuron array (one score per cycle)
//   and the top-level result register, and replaces the wide parallel compare.
// PARAMETERS
//   N_CLASSES  10  number of scores per frame (>=2)
//   DATA_W     8   score width, unsigned unless ARGMAX_SIGNED_EN
//   IDX_W      4   class-index width; must satisfy 2**IDX_W >= N_CLASSES
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   start      in   1       pulse: begin a new frame
//   in_valid   in   1       score on in_data is valid
//   in_data    in   DATA_W  score of class cnt (class 0 first)
//   in_ready   out  1       sequencer accepts a score this cycle
//   res_valid  out  1       max_value holds the frame result
//   res_ready  in   1       consumer accepts the result
//   max_value  out  IDX_W   index of the largest score
//   busy       out  1       frame in progress (state != IDLE)
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): state=IDLE, cnt=0, best=0, max_value=0,
//     in_ready=0, res_valid=0, busy=0. Reset mid-frame abandons the frame; no result.
//   FSM states IDLE, COLLECT, DONE:
//     IDLE: in_ready=0. start=1 -> COLLECT, cnt<=0.
//     COLLECT: in_ready=1. Accept = in_valid & in_ready.
//       - If cnt==0: best<=in_data, max_value<=0.
//       - Else if in_data > best (strict): best<=in_data, max_value<=cnt.
//       - Ties keep the earlier index, so the lowest index among equal maxima wins.
//       - cnt<=cnt+1. Accept with cnt==N_CLASSES-1 -> DONE, cnt<=0.
//       - No accept: hold all registers; gaps in in_valid are allowed.
//     DONE: in_ready=0, res_valid=1. max_value is stable while res_valid=1.
//       - res_ready=1 and start=1 -> COLLECT (back-to-back frame).
//       - res_ready=1 and start=0 -> IDLE.
//       - res_ready=0 -> hold.
//   start is ignored in COLLECT and ignored in DONE unless res_ready=1 that cycle.
//   Latency: res_valid rises the cycle after the N-th accept.
//     Minimum frame is N_CLASSES+1 cycles from start to res_valid.
//   cnt is IDX_W bits wide and never exceeds N_CLASSES-1. There is no wrap within a frame.
//   busy=1 in COLLECT and DONE.
// CONFIGURATION
//   ARGMAX_SIGNED_EN defined: in_data and best are compared as two's-complement signed.
//   ARGMAX_SIGNED_EN undefined: the compare is unsigned. This is the default.
//   No other behaviour changes with the macro.
// TESTING
//   1 Reset then idle: all outputs 0; in_valid=1 with no start -> in_ready stays 0.
//   2 Frame 3,9,1,7,0,2,8,4,5,6 with continuous valid -> max_value=1, res_valid 11 cycles after start.
//   3 Ties: all scores 8'h40 -> max_value=0; scores 5,9,9,... (rest 0) -> max_value=1.
//   4 Random in_valid gaps plus res_ready held low 5 cycles -> result held stable;
//     back-to-back start with res_ready -> next frame correct.
//   5 rst asserted after 4 accepts -> IDLE, res_valid never asserts; the next frame is correct.
//   6 Frame with 8'h80 at class 6, rest 8'h01 -> max_value=6 (default);
//     with ARGMAX_SIGNED_EN -> max_value=0.

Source files
------------

// File: rtl/argmax_sequencer.sv
// argmax_sequencer: serial argmax back-end for the output layer.
// Takes N_CLASSES scores (class 0 first) over a valid/ready stream, keeps a
// running maximum and its index, then presents the winning index with a
// valid/ready result handshake. Ties keep the lowest index.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      pulse: begin a new frame (honoured in IDLE, or in DONE with res_ready)
//   in_valid   score on in_data is valid
//   in_data    score of the current class
//   in_ready   sequencer accepts a score this cycle (COLLECT)
//   res_valid  max_value holds the frame result
//   res_ready  consumer accepts the result
//   max_value  index of the largest score
//   busy       frame in progress (COLLECT or DONE)
//
// Configuration macro: ARGMAX_SIGNED_EN -- when defined, scores are compared as
// two's-complement signed values; otherwise the compare is unsigned.
module argmax_sequencer #(
   parameter int unsigned N_CLASSES = 10,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned IDX_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDX_W-1:0]  max_value,
   output logic              busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  cnt;
   logic [DATA_W-1:0] best;
   logic              accept;
   logic              gt;

   assign accept = in_valid & in_ready;

   // Strict greater-than so equal scores never displace an earlier index.
`ifdef ARGMAX_SIGNED_EN
   assign gt = $signed(in_data) > $signed(best);
`else
   assign gt = in_data > best;
`endif

   // FSM with registered handshake/status outputs updated on each transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         best      <= '0;
         max_value <= '0;
         in_ready  <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= COLLECT;
                  cnt      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end

            COLLECT: begin
               if (accept) begin
                  // First score of a frame seeds the running maximum.
                  if (cnt == '0) begin
                     best      <= in_data;
                     max_value <= '0;
                  end else if (gt) begin
                     best      <= in_data;
                     max_value <= cnt;
                  end
                  if (cnt == LAST_IDX) begin
                     state     <= DONE;
                     cnt       <= '0;
                     in_ready  <= 1'b0;
                     res_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + IDX_W'(1);
                  end
               end
            end

            DONE: begin
               // Result held until consumed; start only counts alongside res_ready.
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (start) begin
                     state    <= COLLECT;
                     cnt      <= '0;
                     in_ready <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               cnt       <= '0;
               in_ready  <= 1'b0;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
